// File: rtl/de0_nano_system_irq_ctrl.sv
`timescale 1ns/1ps
// Interrupt aggregator with a memory-mapped slave port.
// Synchronises the raw irq lines and captures each channel either as a level or as a rising edge.
// Captured bits are masked and ORed into a single registered irq_out.
// Register map (address -> register):
//   0 STATUS  (RO)  synchronised input levels
//   1 PENDING (W1C) write 1 clears edge-mode bits
//   2 MASK    (RW)  1 = channel enabled
//   3 MODE    (RW)  1 = rising-edge capture, 0 = level
//   4 ACTIVE  (RO)  bit15 = any pending & enabled; [3:0] = lowest such channel
//   5 SWTRIG  (WO)  write 1 sets pending on edge-mode channels
//   6 COUNT   (RW)  saturating count of new hardware captures; any write clears it
//   7         reads 0, writes ignored
module de0_nano_system_irq_ctrl #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq_out
);

  localparam int unsigned DW   = 16;
  localparam int unsigned IDXW = 4;
  localparam int unsigned PADW = DW - 1 - IDXW;

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_PENDING = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_MODE    = 3'd3;
  localparam logic [2:0] A_ACTIVE  = 3'd4;
  localparam logic [2:0] A_SWTRIG  = 3'd5;
  localparam logic [2:0] A_COUNT   = 3'd6;

  // Registered state
  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_d [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q,    prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q,    mask_d;
  logic [NUM_IRQ-1:0] mode_q,    mode_d;
  logic [DW-1:0]      count_q,   count_d;
  logic [DW-1:0]      readdata_q, readdata_d;
  logic               irq_out_q, irq_out_d;

  // Combinational helpers
  logic               wr_en;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] s_lvl;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] pend_mask;
  logic [NUM_IRQ-1:0] mode_chg;
  logic [NUM_IRQ-1:0] sw_set;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] edge_next;
  logic               new_capture;
  logic [IDXW-1:0]    active_idx;
  logic               unused_wdata_hi;

  assign wr_en           = chipselect & ~write_n;
  assign wdata           = writedata[NUM_IRQ-1:0];
  assign unused_wdata_hi = ^writedata[DW-1:NUM_IRQ];
  assign s_lvl           = sync_q[SYNC_STAGES-1];
  assign edge_det        = s_lvl & ~prev_q;
  assign pend_mask       = pending_q & mask_q;

  // Synchroniser shift chain and one-cycle delayed level for edge detection
  always_comb begin
    sync_d[0] = irq_in;
    for (int unsigned j = 1; j < SYNC_STAGES; j++) begin
      sync_d[j] = sync_q[j-1];
    end
    prev_d = s_lvl;
  end

  // Decode per-channel write effects
  always_comb begin
    mode_chg = '0;
    sw_set   = '0;
    w1c      = '0;
    if (wr_en && (address == A_MODE))    mode_chg = wdata ^ mode_q;
    if (wr_en && (address == A_SWTRIG))  sw_set   = wdata;
    if (wr_en && (address == A_PENDING)) w1c      = wdata;
  end

  // Pending: level channels copy s; edge channels set-over-clear; a mode change clears the bit
  always_comb begin
    edge_next = (pending_q & ~w1c) | edge_det | sw_set;
    pending_d = ~mode_chg & ((~mode_q & s_lvl) | (mode_q & edge_next));
  end

  // Mask and mode registers
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en && (address == A_MASK)) mask_d = wdata;
    if (wr_en && (address == A_MODE)) mode_d = wdata;
  end

  // Saturating count of new hardware edge captures; a write clears it with priority
  always_comb begin
    new_capture = |(mode_q & edge_det & ~pending_q);
    count_d     = count_q;
    if (wr_en && (address == A_COUNT)) begin
      count_d = '0;
    end else if (new_capture && (count_q != '1)) begin
      count_d = count_q + DW'(1);
    end
  end

  // Fixed priority: lowest-numbered pending and enabled channel wins
  always_comb begin
    active_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (pend_mask[i]) active_idx = IDXW'(i);
    end
  end

  // Read mux, registered every cycle from the presented address
  always_comb begin
    readdata_d = '0;
    case (address)
      A_STATUS:  readdata_d = DW'(s_lvl);
      A_PENDING: readdata_d = DW'(pending_q);
      A_MASK:    readdata_d = DW'(mask_q);
      A_MODE:    readdata_d = DW'(mode_q);
      A_ACTIVE:  readdata_d = {(|pend_mask), PADW'(0), active_idx};
      A_COUNT:   readdata_d = count_q;
      default:   readdata_d = '0;
    endcase
  end

  // Aggregated interrupt to the CPU
  always_comb begin
    irq_out_d = |pend_mask;
  end

  // State register with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
      prev_q     <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      mode_q     <= '0;
      count_q    <= '0;
      readdata_q <= '0;
      irq_out_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      readdata_q <= readdata_d;
      irq_out_q  <= irq_out_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_out  = irq_out_q;

endmodule
